// File: rtl/fp_align_stage.sv
// Compare-and-align stage of the FP adder: orders operands by magnitude, right-aligns the smaller
// mantissa with guard/round/sticky, pre-increments the exponent; valid/ready with a 2-entry skid.
module fp_align_stage #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 24,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               sign_a,
  input  logic               sign_b,
  input  logic [EXP_W-1:0]   exp_a,
  input  logic [EXP_W-1:0]   exp_b,
  input  logic [MAN_W-1:0]   mantissa_a,
  input  logic [MAN_W-1:0]   mantissa_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               large_sign,
  output logic               small_sign,
  output logic [EXP_W-1:0]   exp_out,
  output logic [MAN_W+2:0]   large_man,
  output logic [MAN_W+2:0]   small_man,
  output logic               swap,
  output logic               exp_ovf,
  output logic               small_zero,
  output logic [TAG_W-1:0]   out_tag
);
  localparam int XW = MAN_W + 3;

  typedef struct packed {
    logic             large_sign;
    logic             small_sign;
    logic [EXP_W-1:0] exp_out;
    logic [XW-1:0]    large_man;
    logic [XW-1:0]    small_man;
    logic             swap;
    logic             exp_ovf;
    logic             small_zero;
    logic [TAG_W-1:0] tag;
  } res_t;

  logic             b_big, far, ovf;
  logic [EXP_W-1:0] e_max, d;
  logic [MAN_W-1:0] m_big, m_small;
  logic [XW-1:0]    ext, mask, shifted, aligned;
  res_t             nxt, out_q, skid_q;
  logic             out_v, skid_v, take;

  assign b_big   = (exp_b > exp_a) || ((exp_b == exp_a) && (mantissa_b > mantissa_a));
  assign e_max   = b_big ? exp_b : exp_a;
  assign d       = b_big ? exp_b - exp_a : exp_a - exp_b;
  assign m_big   = b_big ? mantissa_b : mantissa_a;
  assign m_small = b_big ? mantissa_a : mantissa_b;

  // Shift-out bits collapse into bit 0; beyond the field width only a nonzero flag survives.
  assign ext     = {m_small, 3'b000};
  assign far     = 32'(d) >= XW;
  assign mask    = ~({XW{1'b1}} << d);
  assign shifted = ext >> d;
  assign aligned = far ? {{(XW-1){1'b0}}, |m_small}
                       : {shifted[XW-1:1], shifted[0] | (|(ext & mask))};

  assign ovf = &e_max;

  always_comb begin
    nxt            = '0;
    nxt.large_sign = b_big ? sign_b : sign_a;
    nxt.small_sign = b_big ? sign_a : sign_b;
    nxt.exp_out    = ovf ? e_max : e_max + 1'b1;
    nxt.large_man  = {m_big, 3'b000};
    nxt.small_man  = aligned;
    nxt.swap       = b_big;
    nxt.exp_ovf    = ovf;
    nxt.small_zero = (m_small == '0);
    nxt.tag        = in_tag;
  end

  assign in_ready = !skid_v;
  assign take     = in_valid && !skid_v;

  // Skid only fills when the output register is stalled; it always empties first on drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      out_q  <= '0;
      skid_q <= '0;
    end else if (!out_v || out_ready) begin
      if (skid_v) begin
        out_q  <= skid_q;
        out_v  <= 1'b1;
        skid_v <= 1'b0;
      end else begin
        out_v <= take;
        if (take) out_q <= nxt;
      end
    end else if (take) begin
      skid_q <= nxt;
      skid_v <= 1'b1;
    end
  end

  assign out_valid  = out_v;
  assign large_sign = out_q.large_sign;
  assign small_sign = out_q.small_sign;
  assign exp_out    = out_q.exp_out;
  assign large_man  = out_q.large_man;
  assign small_man  = out_q.small_man;
  assign swap       = out_q.swap;
  assign exp_ovf    = out_q.exp_ovf;
  assign small_zero = out_q.small_zero;
  assign out_tag    = out_q.tag;
endmodule

// File: tb/tb_fp_align_stage.sv
// Scoreboard bench for fp_align_stage: arithmetic reference model, random + directed stimulus,
// backpressure, hold-stability and mid-stall reset.
module tb_fp_align_stage;
  localparam int EXP_W = 8;
  localparam int MAN_W = 24;
  localparam int TAG_W = 4;
  localparam int EMAX  = (1 << EXP_W) - 1;

  logic             clk, rst_n;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic             sign_a, sign_b, large_sign, small_sign, swap, exp_ovf, small_zero;
  logic [EXP_W-1:0] exp_a, exp_b, exp_out;
  logic [MAN_W-1:0] mantissa_a, mantissa_b;
  logic [MAN_W+2:0] large_man, small_man;
  logic [TAG_W-1:0] in_tag, out_tag;

  fp_align_stage #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sign_a(sign_a), .sign_b(sign_b), .exp_a(exp_a), .exp_b(exp_b),
    .mantissa_a(mantissa_a), .mantissa_b(mantissa_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .large_sign(large_sign),
    .small_sign(small_sign), .exp_out(exp_out), .large_man(large_man),
    .small_man(small_man), .swap(swap), .exp_ovf(exp_ovf), .small_zero(small_zero),
    .out_tag(out_tag)
  );

  typedef struct {
    bit sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic [TAG_W-1:0] tag;
  } stim_t;

  typedef struct {
    bit ls, ss, sw, ovf, sz;
    longint unsigned eo, lm, sm, tag;
  } res_t;

  res_t q[$];
  int   checks = 0, failures = 0;
  int   rdy_mode = 0;  // 0 random, 1 hold low, 2 hold high

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input longint unsigned act, input longint unsigned req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Value-level model: pick the larger magnitude, divide the scaled smaller mantissa by 2^d,
  // and fold any nonzero remainder into the lowest bit.
  function automatic res_t model(input stim_t s);
    res_t r;
    longint unsigned ea, eb, ma, mb, big_e, d, sm, ext, p;
    bit bb;
    ea = 64'(s.ea); eb = 64'(s.eb); ma = 64'(s.ma); mb = 64'(s.mb);
    bb = (eb > ea) || (eb == ea && mb > ma);
    big_e = bb ? eb : ea;
    d     = bb ? eb - ea : ea - eb;
    sm    = bb ? ma : mb;
    r.sw  = bb;
    r.ls  = bb ? s.sb : s.sa;
    r.ss  = bb ? s.sa : s.sb;
    r.ovf = (big_e == EMAX);
    r.eo  = r.ovf ? big_e : big_e + 1;
    r.lm  = (bb ? mb : ma) * 8;
    ext   = sm * 8;
    if (d >= MAN_W + 3) r.sm = (sm != 0) ? 1 : 0;
    else begin
      p = 1;
      for (longint unsigned i = 0; i < d; i++) p = p * 2;
      r.sm = ext / p;
      if (ext % p != 0) r.sm = r.sm | 1;
    end
    r.sz  = (sm == 0);
    r.tag = 64'(s.tag);
    return r;
  endfunction

  function automatic stim_t rand_stim(input int tag);
    stim_t s;
    int k;
    s.sa = 1'($urandom); s.sb = 1'($urandom);
    s.ea = EXP_W'($urandom);
    k = int'($urandom_range(0, 9));
    if (k < 2) s.eb = s.ea;
    else if (k == 2) s.eb = 8'hFF;
    else if (k == 3) s.eb = EXP_W'($urandom);
    else s.eb = s.ea + EXP_W'($urandom_range(0, 40)) - 8'd20;
    s.ma = {1'b1, 23'($urandom)};
    s.mb = {1'b1, 23'($urandom)};
    k = int'($urandom_range(0, 9));
    if (k == 0) s.ma = '0;
    else if (k == 1) s.mb = '0;
    else if (k == 2) s.mb = s.ma;
    s.tag = TAG_W'(tag);
    return s;
  endfunction

  task automatic drive(input stim_t s);
    in_valid = 1'b1; sign_a = s.sa; sign_b = s.sb; exp_a = s.ea; exp_b = s.eb;
    mantissa_a = s.ma; mantissa_b = s.mb; in_tag = s.tag;
  endtask

  // Called right after a negedge; returns right after the negedge following acceptance.
  task automatic send(input stim_t s, input res_t e);
    int n = 0;
    drive(s);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 0, 1);
    else q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    rdy_mode = 2;
    while ((q.size() != 0 || out_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 64'(q.size()) + 64'(out_valid), 0);
  endtask

  // Monitor: owns out_ready, pops and compares on every transfer out, checks hold while stalled.
  initial begin
    res_t r;
    bit held_v = 0;
    logic [70:0] held = '0, cur;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      out_ready = (rdy_mode == 2) || (rdy_mode == 0 && $urandom_range(0, 9) < 7);
      cur = {large_sign, small_sign, exp_out, large_man, small_man, swap, exp_ovf, small_zero, out_tag};
      if (rst_n && held_v) begin
        check("hold_man", 64'(cur[60:7]), 64'(held[60:7]));
        check("hold_misc", 64'({cur[70:61], cur[6:0]}), 64'({held[70:61], held[6:0]}));
      end
      held_v = rst_n && out_valid && !out_ready;
      held   = cur;
      if (rst_n && out_valid && out_ready) begin
        if (q.size() == 0) check("unexpected_out_tag", 64'(out_tag) + 64'h100, 0);
        else begin
          r = q.pop_front();
          check("out_tag", 64'(out_tag), r.tag);
          check("swap", 64'(swap), 64'(r.sw));
          check("large_sign", 64'(large_sign), 64'(r.ls));
          check("small_sign", 64'(small_sign), 64'(r.ss));
          check("exp_out", 64'(exp_out), r.eo);
          check("exp_ovf", 64'(exp_ovf), 64'(r.ovf));
          check("large_man", 64'(large_man), r.lm);
          check("small_man", 64'(small_man), r.sm);
          check("small_zero", 64'(small_zero), 64'(r.sz));
        end
      end
    end
  end

  initial begin
    stim_t s;
    res_t  e;
    int    n;
    rst_n = 1'b0; in_valid = 1'b0; sign_a = 0; sign_b = 0; exp_a = '0; exp_b = '0;
    mantissa_a = '0; mantissa_b = '0; in_tag = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_in_ready", 64'(in_ready), 1);
    check("rst_data", 64'(large_man) | 64'(small_man) | 64'(exp_out) | 64'(out_tag), 0);
    rst_n = 1'b1;
    rdy_mode = 2;

    // basic alignment, one-cycle latency
    s = '{sa:0, sb:1, ea:8'h82, eb:8'h80, ma:24'hC00000, mb:24'h800000, tag:4'h5};
    e = model(s); e.sw = 0; e.eo = 'h83; e.lm = 'h6000000; e.sm = 'h1000000; e.ovf = 0;
    send(s, e);
    check("latency_out_valid", 64'(out_valid), 1);
    drain();
    // swap with guard/round bits
    s = '{sa:0, sb:1, ea:8'h7F, eb:8'h81, ma:24'h800001, mb:24'h812345, tag:4'h6};
    e = model(s); e.sw = 1; e.eo = 'h82; e.sm = 'h1000002; e.ls = 1;
    send(s, e);
    // large shift, nonzero and zero small mantissa
    s = '{sa:1, sb:0, ea:8'hA8, eb:8'h80, ma:24'hFFFFFF, mb:24'h800000, tag:4'h7};
    e = model(s); e.sm = 'h1;
    send(s, e);
    s.mb = '0; s.tag = 4'h8;
    e = model(s); e.sm = 0; e.sz = 1;
    send(s, e);
    // equal exponent tie-break
    s = '{sa:0, sb:0, ea:8'h90, eb:8'h90, ma:24'h900000, mb:24'hA00000, tag:4'h9};
    e = model(s); e.sw = 1; e.eo = 'h91; e.sm = 'h4800000;
    send(s, e);
    s.mb = 24'h900000; s.tag = 4'hA;
    e = model(s); e.sw = 0;
    send(s, e);
    // saturation
    s = '{sa:0, sb:1, ea:8'hFF, eb:8'h10, ma:24'h800000, mb:24'hC00000, tag:4'hB};
    e = model(s); e.eo = 'hFF; e.ovf = 1;
    send(s, e);
    drain();

    // backpressure: tags 1,2 taken, 3 refused until drain
    rdy_mode = 1;
    @(negedge clk);
    s = rand_stim(1); drive(s);
    check("bp_ready_t1", 64'(in_ready), 1);
    q.push_back(model(s));
    @(negedge clk);
    s = rand_stim(2); drive(s);
    check("bp_ready_t2", 64'(in_ready), 1);
    q.push_back(model(s));
    @(negedge clk);
    s = rand_stim(3); drive(s);
    check("bp_ready_full", 64'(in_ready), 0);
    check("bp_out_valid", 64'(out_valid), 1);
    check("bp_out_tag", 64'(out_tag), 1);
    @(negedge clk);
    check("bp_ready_still_full", 64'(in_ready), 0);
    rdy_mode = 2;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_reaccept", 64'(in_ready), 1);
    q.push_back(model(s));
    @(negedge clk);
    in_valid = 1'b0;
    drain();

    // reset in the middle of a stall discards both entries
    rdy_mode = 1;
    s = rand_stim(4); send(s, model(s));
    s = rand_stim(5); send(s, model(s));
    rst_n = 1'b0;
    s = rand_stim(6); drive(s);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    q.delete();
    check("midrst_out_valid", 64'(out_valid), 0);
    check("midrst_in_ready", 64'(in_ready), 1);
    check("midrst_data", 64'(large_man) | 64'(small_man) | 64'(exp_out) | 64'(out_tag), 0);
    rdy_mode = 2;
    @(negedge clk);
    check("midrst_no_stale", 64'(out_valid), 0);

    // random traffic with random backpressure
    rdy_mode = 0;
    for (int i = 0; i < 300; i++) begin
      s = rand_stim(i);
      send(s, model(s));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
